// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its load aligner.
package dmem_pkg;

  localparam int unsigned REQ_ADDR_W  = 9;
  localparam int unsigned DMEM_DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  typedef struct packed {
    logic                   op_rd;
    logic                   op_wr;
    logic [REQ_ADDR_W-1:0]  addr;
    logic [DMEM_DATA_W-1:0] wr_data;
    logic [2:0]             funct3;
    logic                   err;
  } dmem_req_t;

  // Flags conflicting ops, illegal funct3 and misaligned halfword/word accesses.
  function automatic logic req_err(input logic       rd,
                                   input logic       wr,
                                   input logic [1:0] byte_off,
                                   input logic [2:0] f3);
    logic e;
    e = rd & wr;
    case (f3)
      F3_B, F3_BU: e = e;
      F3_H, F3_HU: e = e | byte_off[0];
      F3_W:        e = e | (|byte_off);
      default:     e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Picks the addressed byte/halfword out of a storage word and sign/zero-extends it.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  byte_off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_c_o
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c = 8'h00;
    case (byte_off_i)
      2'd0:    byte_c = word_i[7:0];
      2'd1:    byte_c = word_i[15:8];
      2'd2:    byte_c = word_i[23:16];
      default: byte_c = word_i[31:24];
    endcase
    half_c = byte_off_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    data_c_o = 32'h0000_0000;
    case (funct3_i)
      F3_B:    data_c_o = {{24{byte_c[7]}}, byte_c};
      F3_H:    data_c_o = {{16{half_c[15]}}, half_c};
      F3_W:    data_c_o = word_i;
      F3_BU:   data_c_o = {24'h000000, byte_c};
      F3_HU:   data_c_o = {16'h0000, half_c};
      default: data_c_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Target end of the load/store port: accepts one request, waits WAIT_CYCLES,
// then commits a store or returns a load with a one-cycle ready/err pulse.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DM_ADDRESS  = REQ_ADDR_W,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_rd,
  input  logic                  mem_wr,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [2:0]            funct3,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  ready,
  output logic                  err,
  output logic                  busy
);

  localparam int unsigned WORD_IDX_W = DM_ADDRESS - 2;
  localparam int unsigned WORDS      = 2 ** WORD_IDX_W;
  localparam int unsigned CNT_W      = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  dmem_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dmem_req_t req_q, req_d, req_new_c, req_cur_c;
  logic enter_resp_c;

  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic [31:0]           mem_q [WORDS];
  logic [DM_ADDRESS-1:0] addr_c;
  logic [WORD_IDX_W-1:0] word_idx_c;
  logic [1:0]            byte_off_c;
  logic [31:0]           load_c;
  logic                  wr_en_c;
  logic [3:0]            wr_be_c;
  logic [31:0]           wr_word_c;

  // In IDLE the live inputs are the request; afterwards the latched copy is.
  always_comb begin
    req_new_c.op_rd   = mem_rd;
    req_new_c.op_wr   = mem_wr;
    req_new_c.addr    = REQ_ADDR_W'(addr);
    req_new_c.wr_data = DMEM_DATA_W'(wr_data);
    req_new_c.funct3  = funct3;
    req_new_c.err     = req_err(mem_rd, mem_wr, addr[1:0], funct3);
    req_cur_c         = (state_q == IDLE) ? req_new_c : req_q;
  end

  assign addr_c     = DM_ADDRESS'(req_cur_c.addr);
  assign word_idx_c = addr_c[DM_ADDRESS-1:2];
  assign byte_off_c = addr_c[1:0];

  dmem_load_align u_load_align (
    .word_i     (mem_q[word_idx_c]),
    .byte_off_i (byte_off_c),
    .funct3_i   (req_cur_c.funct3),
    .data_c_o   (load_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    enter_resp_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_rd || mem_wr) begin
          req_d = req_new_c;
          if (WAIT_CYCLES == 0) begin
            state_d      = RESP;
            enter_resp_c = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d      = RESP;
          enter_resp_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_d   = 1'b0;
    err_d     = 1'b0;
    busy_d    = (state_d != IDLE);
    rd_data_d = rd_data_q;
    wr_en_c   = 1'b0;
    if (enter_resp_c) begin
      ready_d   = 1'b1;
      err_d     = req_cur_c.err;
      rd_data_d = (req_cur_c.op_rd && !req_cur_c.err) ? DATA_W'(load_c) : '0;
      wr_en_c   = req_cur_c.op_wr && !req_cur_c.err;
    end
    case (req_cur_c.funct3[1:0])
      2'b00: begin
        wr_be_c   = 4'b0001 << byte_off_c;
        wr_word_c = {4{req_cur_c.wr_data[7:0]}};
      end
      2'b01: begin
        wr_be_c   = byte_off_c[1] ? 4'b1100 : 4'b0011;
        wr_word_c = {2{req_cur_c.wr_data[15:0]}};
      end
      default: begin
        wr_be_c   = 4'b1111;
        wr_word_c = req_cur_c.wr_data;
      end
    endcase
  end

  // Storage survives reset; a reset on the commit edge drops the store.
  always_ff @(posedge clk) begin
    if (wr_en_c && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be_c[b]) mem_q[word_idx_c][8*b +: 8] <= wr_word_c[8*b +: 8];
      end
    end
  end

  assign rd_data = rd_data_q;
  assign ready   = ready_q;
  assign err     = err_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states, one with none.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        a_rd, a_wr, a_ready, a_err, a_busy;
  logic [8:0]  a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic [2:0]  a_f3;

  logic        z_rd, z_wr, z_ready, z_err, z_busy;
  logic [8:0]  z_addr;
  logic [31:0] z_wdata, z_rdata;
  logic [2:0]  z_f3;

  int checks = 0;
  int passed = 0;

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .mem_rd(a_rd), .mem_wr(a_wr), .addr(a_addr),
    .wr_data(a_wdata), .funct3(a_f3), .rd_data(a_rdata), .ready(a_ready),
    .err(a_err), .busy(a_busy)
  );

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .reset(reset), .mem_rd(z_rd), .mem_wr(z_wr), .addr(z_addr),
    .wr_data(z_wdata), .funct3(z_f3), .rd_data(z_rdata), .ready(z_ready),
    .err(z_err), .busy(z_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, want);
  endtask

  task automatic drive(input bit z, input logic rd, input logic wr, input logic [8:0] ad,
                       input logic [31:0] wd, input logic [2:0] f3);
    if (z) begin
      z_rd = rd; z_wr = wr; z_addr = ad; z_wdata = wd; z_f3 = f3;
    end else begin
      a_rd = rd; a_wr = wr; a_addr = ad; a_wdata = wd; a_f3 = f3;
    end
  endtask

  function automatic logic [31:0] out_rdata(input bit z);
    return z ? z_rdata : a_rdata;
  endfunction

  function automatic logic [2:0] out_flags(input bit z);
    return z ? {z_ready, z_err, z_busy} : {a_ready, a_err, a_busy};
  endfunction

  // One full request/response; checks latency, err, rd_data and the pulse shape.
  task automatic access(input bit z, input string tag, input logic rd, input logic wr,
                        input logic [8:0] ad, input logic [31:0] wd, input logic [2:0] f3,
                        input logic [31:0] want_rd, input logic want_err);
    int  cyc;
    bit  got;
    logic [2:0] fl;
    cyc = 0;
    got = 1'b0;
    drive(z, rd, wr, ad, wd, f3);
    while (!got && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      fl = out_flags(z);
      if (cyc == 1) check({tag, "/busy"}, 32'(fl[0]), 32'd1);
      if (fl[2]) got = 1'b1;
    end
    drive(z, 1'b0, 1'b0, 9'h000, 32'h0, 3'b000);
    fl = out_flags(z);
    check({tag, "/latency"}, 32'(cyc), z ? 32'd1 : 32'd3);
    check({tag, "/err"}, 32'(fl[1]), 32'(want_err));
    check({tag, "/rd_data"}, out_rdata(z), want_rd);
    @(posedge clk); #1;
    fl = out_flags(z);
    check({tag, "/after"}, 32'(fl), 32'd0);
    check({tag, "/hold"}, out_rdata(z), want_rd);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 9'h000, 32'h0, 3'b000);
    drive(1'b1, 1'b0, 1'b0, 9'h000, 32'h0, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    check("reset/flags_a", 32'(out_flags(1'b0)), 32'd0);
    check("reset/rd_data_a", a_rdata, 32'h0);
    check("reset/flags_z", 32'(out_flags(1'b1)), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    access(1'b0, "sw010",  1'b0, 1'b1, 9'h010, 32'hDEADBEEF, F3_W,  32'h00000000, 1'b0);
    access(1'b0, "lw010",  1'b1, 1'b0, 9'h010, 32'h0,        F3_W,  32'hDEADBEEF, 1'b0);
    access(1'b0, "lb013",  1'b1, 1'b0, 9'h013, 32'h0,        F3_B,  32'hFFFFFFDE, 1'b0);
    access(1'b0, "lbu013", 1'b1, 1'b0, 9'h013, 32'h0,        F3_BU, 32'h000000DE, 1'b0);
    access(1'b0, "lh012",  1'b1, 1'b0, 9'h012, 32'h0,        F3_H,  32'hFFFFDEAD, 1'b0);
    access(1'b0, "lhu010", 1'b1, 1'b0, 9'h010, 32'h0,        F3_HU, 32'h0000BEEF, 1'b0);
    access(1'b0, "sb011",  1'b0, 1'b1, 9'h011, 32'h00000055, F3_B,  32'h00000000, 1'b0);
    access(1'b0, "lw_sb",  1'b1, 1'b0, 9'h010, 32'h0,        F3_W,  32'hDEAD55EF, 1'b0);
    access(1'b0, "sh012",  1'b0, 1'b1, 9'h012, 32'h00001234, F3_H,  32'h00000000, 1'b0);
    access(1'b0, "lw_sh",  1'b1, 1'b0, 9'h010, 32'h0,        F3_W,  32'h123455EF, 1'b0);

    access(1'b0, "lw012_mis", 1'b1, 1'b0, 9'h012, 32'h0,        F3_W, 32'h0, 1'b1);
    access(1'b0, "sh011_mis", 1'b0, 1'b1, 9'h011, 32'h0000FFFF, F3_H, 32'h0, 1'b1);
    access(1'b0, "lw_mis",    1'b1, 1'b0, 9'h010, 32'h0,        F3_W, 32'h123455EF, 1'b0);
    access(1'b0, "rdwr_both", 1'b1, 1'b1, 9'h010, 32'h0,        F3_W, 32'h0, 1'b1);
    access(1'b0, "lw_both",   1'b1, 1'b0, 9'h010, 32'h0,        F3_W, 32'h123455EF, 1'b0);
    access(1'b0, "f3_011",    1'b0, 1'b1, 9'h010, 32'h0,        3'b011, 32'h0, 1'b1);
    access(1'b0, "lw_f3",     1'b1, 1'b0, 9'h010, 32'h0,        F3_W, 32'h123455EF, 1'b0);

    // Reset lands on the would-be commit edge of a store.
    access(1'b0, "sw020_zero", 1'b0, 1'b1, 9'h020, 32'h00000000, F3_W, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 9'h020, 32'hAAAAAAAA, F3_W);
    @(posedge clk); #1;
    check("abort/busy_accept", 32'(a_busy), 32'd1);
    @(posedge clk); #1;
    check("abort/no_ready_yet", 32'(a_ready), 32'd0);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 9'h000, 32'h0, 3'b000);
    @(posedge clk); #1;
    check("abort/flags", 32'(out_flags(1'b0)), 32'd0);
    check("abort/rd_data", a_rdata, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    access(1'b0, "lw020_after_abort", 1'b1, 1'b0, 9'h020, 32'h0, F3_W, 32'h00000000, 1'b0);

    // Zero wait states: held load request responds on alternate cycles.
    access(1'b1, "z_sw040", 1'b0, 1'b1, 9'h040, 32'hCAFEF00D, F3_W, 32'h0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 9'h040, 32'h0, F3_W);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check($sformatf("z_b2b/ready%0d", i), 32'(z_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (z_ready) check($sformatf("z_b2b/rd_data%0d", i), z_rdata, 32'hCAFEF00D);
    end
    drive(1'b1, 1'b0, 1'b0, 9'h000, 32'h0, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    check("z_idle/flags", 32'(out_flags(1'b1)), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
